// File: rtl/ysyx_23060278_ifu_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
package ysyx_23060278_ifu_pkg;

    // FSM encoding kept as plain constants so older tools and waveform
    // viewers see stable numeric values.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_AR   = 2'd1;
    localparam state_t ST_R    = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    // Instructions are word aligned; any set low address bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & MISALIGN_MASK);
    endfunction

endpackage

// File: rtl/ysyx_23060278_ifu_if.sv
// AXI-lite-style read-only instruction memory channel (AR + R).
interface ysyx_23060278_ifu_if #(
    parameter int ADDR_W = 32
);
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rready;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ysyx_23060278_ifu_timer.sv
// Saturating cycle counter for the read-response timeout.
// count holds the number of R cycles already completed; expired flags the
// TIMEOUT_CYCLES-th cycle so the FSM leaves R after exactly that many cycles.
module ysyx_23060278_ifu_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam bit           ENABLED = (TIMEOUT_CYCLES != 0);
    localparam int           W       = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT   = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST    = ENABLED ? W'(TIMEOUT_CYCLES - 1) : '0;

    logic [W-1:0] count;

    // Count cycles in R, restart on entry, hold at the limit.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: one outstanding read on the imem AR/R channel,
// result handed to the core over a valid/ready handshake.
module ysyx_23060278_ifu
    import ysyx_23060278_ifu_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               fetch_start,
    input  logic               flush,
    ysyx_23060278_ifu_if.master imem,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic               inst_fault,
    output logic               busy
);
    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic              fault_q;
    logic              stale_q;   // a timed-out response is still owed by memory
    logic              drop_q;    // current fetch was flushed, discard its response

    logic accept;
    logic ar_fire;
    logic expired;
    logic discard;

    // A new fetch is taken from an idle, clean unit or from OUT as the result
    // is consumed; flush always wins.
    assign accept  = fetch_start && !flush &&
                     ((state == ST_IDLE && !stale_q) || (state == ST_OUT && inst_ready));
    assign ar_fire = imem.arvalid && imem.arready;
    assign discard = drop_q || flush;

    assign imem.arvalid = (state == ST_AR) && !stale_q;
    assign imem.araddr  = pc_q;
    assign imem.rready  = (state == ST_R) || stale_q;

    assign inst_valid = (state == ST_OUT);
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign inst_fault = fault_q;
    assign busy       = (state != ST_IDLE) || stale_q;

    ysyx_23060278_ifu_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (ar_fire),
        .enable (state == ST_R),
        .expired(expired)
    );

    // Fetch FSM with flush, drop and stale bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
            stale_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            // Only R can time out, and R is never entered while stale.
            if (stale_q && imem.rvalid) begin
                stale_q <= 1'b0;
            end else if (state == ST_R && !imem.rvalid && expired) begin
                stale_q <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_OUT: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        pc_q <= pc_in;
                        if (is_misaligned(pc_in[1:0])) begin
                            state   <= ST_OUT;
                            inst_q  <= NOP_INST;
                            fault_q <= 1'b1;
                        end else begin
                            state <= ST_AR;
                        end
                    end else if (inst_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    // An asserted arvalid is never withdrawn; a flush before
                    // arvalid rises (stale wait) can abandon the fetch outright.
                    if (flush && !imem.arvalid) begin
                        state <= ST_IDLE;
                    end else begin
                        if (flush) drop_q <= 1'b1;
                        if (ar_fire) state <= ST_R;
                    end
                end
                ST_R: begin
                    if (imem.rvalid || expired) begin
                        if (discard) begin
                            state  <= ST_IDLE;
                            drop_q <= 1'b0;
                        end else begin
                            state <= ST_OUT;
                            if (imem.rvalid && imem.rresp == RESP_OKAY) begin
                                inst_q  <= imem.rdata;
                                fault_q <= 1'b0;
                            end else begin
                                inst_q  <= NOP_INST;
                                fault_q <= 1'b1;
                            end
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A fetch request while busy (outside the OUT/inst_ready slot) is dropped.
    fetch_while_busy: assert property (@(posedge clk) disable iff (rst)
        !(fetch_start && busy && !flush && !(state == ST_OUT && inst_ready)));

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Self-checking bench for ysyx_23060278_ifu: table-driven fetches plus
// hand-written flush, timeout/stale, back-to-back and reset sequences.
module tb_ysyx_23060278_ifu;
    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        busy;

    ysyx_23060278_ifu_if #(.ADDR_W(32)) imem ();

    ysyx_23060278_ifu #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(8),
        .NOP_INST      (NOP_I)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .fetch_start(fetch_start),
        .flush      (flush),
        .imem       (imem),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          ar_delay;
        int          r_delay;
        int          ready_delay;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ar_count = 0;
    int   valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, between stimulus updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem.arvalid && imem.arready) ar_count++;
            if (inst_valid) valid_cycles++;
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: inst handshake with inst=%h pc=%h, nothing expected", inst, inst_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_inst", inst, e.inst);
                    check("sb_pc", inst_pc, e.pc);
                    check("sb_fault", {31'b0, inst_fault}, {31'b0, e.fault});
                end
            end
        end
    end

    // One complete fetch with programmable bus and consumer delays.
    task automatic do_fetch(input vec_t v);
        int   ar0;
        exp_t e;
        bit   mis;
        mis = (v.pc[1:0] != 2'b00);
        check("pre_busy", {31'b0, busy}, 32'd0);
        ar0 = ar_count;
        e.inst = v.exp_inst;
        e.pc = v.pc;
        e.fault = v.exp_fault;
        sb.push_back(e);
        pc_in = v.pc;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        pc_in = 32'h0;
        if (mis) begin
            check("mis_arvalid", {31'b0, imem.arvalid}, 32'd0);
        end else begin
            for (int i = 0; i < v.ar_delay; i++) begin
                check("ar_wait_arvalid", {31'b0, imem.arvalid}, 32'd1);
                check("ar_wait_araddr", imem.araddr, v.pc);
                tick();
            end
            check("ar_arvalid", {31'b0, imem.arvalid}, 32'd1);
            check("ar_araddr", imem.araddr, v.pc);
            imem.arready = 1'b1;
            tick();
            imem.arready = 1'b0;
            for (int i = 0; i < v.r_delay; i++) begin
                check("r_wait_rready", {31'b0, imem.rready}, 32'd1);
                check("r_wait_arvalid", {31'b0, imem.arvalid}, 32'd0);
                check("r_wait_valid", {31'b0, inst_valid}, 32'd0);
                tick();
            end
            imem.rvalid = 1'b1;
            imem.rdata = v.rdata;
            imem.rresp = v.rresp;
            check("r_rready", {31'b0, imem.rready}, 32'd1);
            check("r_valid_early", {31'b0, inst_valid}, 32'd0);
            tick();
            imem.rvalid = 1'b0;
            imem.rdata = '0;
            imem.rresp = '0;
        end
        check("out_valid", {31'b0, inst_valid}, 32'd1);
        for (int i = 0; i < v.ready_delay; i++) begin
            check("hold_valid", {31'b0, inst_valid}, 32'd1);
            check("hold_inst", inst, v.exp_inst);
            check("hold_pc", inst_pc, v.pc);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("post_valid", {31'b0, inst_valid}, 32'd0);
        check("ar_handshakes", ar_count - ar0, mis ? 32'd0 : 32'd1);
    endtask

    // Global bound so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   v0;

        // pc, ar_delay, r_delay, ready_delay, rdata, rresp, exp_inst, exp_fault
        vecs[0] = '{32'h8000_0000, 0, 0, 0, 32'h0010_0093, 2'b00, 32'h0010_0093, 1'b0};
        vecs[1] = '{32'h8000_0010, 4, 2, 3, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
        vecs[2] = '{32'h8000_0002, 0, 0, 0, 32'h0,         2'b00, NOP_I,         1'b1};
        vecs[3] = '{32'h8000_0020, 1, 1, 0, 32'h0000_00ff, 2'b10, NOP_I,         1'b1};
        vecs[4] = '{32'h8000_0001, 0, 0, 2, 32'h0,         2'b00, NOP_I,         1'b1};
        vecs[5] = '{32'h0000_0ffc, 0, 4, 1, 32'hcafe_f00d, 2'b00, 32'hcafe_f00d, 1'b0};

        imem.arready = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        imem.rresp = '0;

        // Reset values.
        tick();
        tick();
        check("rst_arvalid", {31'b0, imem.arvalid}, 32'd0);
        check("rst_rready", {31'b0, imem.rready}, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_fault", {31'b0, inst_fault}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_inst", inst, NOP_I);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_araddr", imem.araddr, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

        // Flush while in AR: address handshake still completes, response dropped.
        v0 = valid_cycles;
        pc_in = 32'h8000_0030;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flar_arvalid_kept", {31'b0, imem.arvalid}, 32'd1);
        check("flar_busy", {31'b0, busy}, 32'd1);
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata = 32'h1111_1111;
        check("flar_rready", {31'b0, imem.rready}, 32'd1);
        tick();
        imem.rvalid = 1'b0;
        check("flar_busy_after", {31'b0, busy}, 32'd0);
        check("flar_no_valid", valid_cycles - v0, 32'd0);

        // Flush one cycle after the AR handshake.
        v0 = valid_cycles;
        pc_in = 32'h8000_0040;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        imem.rvalid = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        check("flr_rready", {31'b0, imem.rready}, 32'd1);
        tick();
        imem.rvalid = 1'b0;
        check("flr_busy_after", {31'b0, busy}, 32'd0);
        check("flr_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("flr_no_valid", valid_cycles - v0, 32'd0);

        // Timeout after 8 cycles in R, then stale response blocks the next AR.
        e = '{NOP_I, 32'h8000_0080, 1'b1};
        sb.push_back(e);
        pc_in = 32'h8000_0080;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to_wait_valid", {31'b0, inst_valid}, 32'd0);
            tick();
        end
        check("to_valid", {31'b0, inst_valid}, 32'd1);
        check("to_fault", {31'b0, inst_fault}, 32'd1);
        check("to_inst", inst, NOP_I);
        e = '{32'h0000_0513, 32'h8000_0084, 1'b0};
        sb.push_back(e);
        pc_in = 32'h8000_0084;
        fetch_start = 1'b1;
        inst_ready = 1'b1;
        tick();
        fetch_start = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stale_arvalid", {31'b0, imem.arvalid}, 32'd0);
            check("stale_rready", {31'b0, imem.rready}, 32'd1);
            check("stale_busy", {31'b0, busy}, 32'd1);
            tick();
        end
        imem.rvalid = 1'b1;
        imem.rdata = 32'hBAD0_BAD0;
        tick();
        imem.rvalid = 1'b0;
        check("stale_cleared_arvalid", {31'b0, imem.arvalid}, 32'd1);
        check("stale_cleared_araddr", imem.araddr, 32'h8000_0084);
        check("stale_no_valid", {31'b0, inst_valid}, 32'd0);
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata = 32'h0000_0513;
        tick();
        imem.rvalid = 1'b0;
        check("after_stale_valid", {31'b0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // Back-to-back: consume and start in the same OUT cycle.
        e = '{32'h00a0_0113, 32'h8000_0100, 1'b0};
        sb.push_back(e);
        pc_in = 32'h8000_0100;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata = 32'h00a0_0113;
        tick();
        imem.rvalid = 1'b0;
        check("b2b_valid", {31'b0, inst_valid}, 32'd1);
        e = '{32'h0, 32'h8000_0004, 1'b0};
        sb.push_back(e);
        pc_in = 32'h8000_0004;
        fetch_start = 1'b1;
        inst_ready = 1'b1;
        tick();
        fetch_start = 1'b0;
        inst_ready = 1'b0;
        check("b2b_arvalid", {31'b0, imem.arvalid}, 32'd1);
        check("b2b_araddr", imem.araddr, 32'h8000_0004);
        check("b2b_valid_drop", {31'b0, inst_valid}, 32'd0);
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;

        // Reset while in R abandons the transaction.
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check("mid_rst_arvalid", {31'b0, imem.arvalid}, 32'd0);
        check("mid_rst_rready", {31'b0, imem.rready}, 32'd0);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_fault", {31'b0, inst_fault}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_inst", inst, NOP_I);
        check("mid_rst_pc", inst_pc, 32'd0);
        check("mid_rst_araddr", imem.araddr, 32'd0);
        imem.rvalid = 1'b1;
        imem.rdata = 32'h7777_7777;
        tick();
        imem.rvalid = 1'b0;
        check("late_r_valid", {31'b0, inst_valid}, 32'd0);
        check("late_r_busy", {31'b0, busy}, 32'd0);

        do_fetch(vecs[0]);
        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
